// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that streams operands through one
// shared 4-bit carry-lookahead adder, least-significant nibble first, with a
// registered carry chaining between nibbles. A valid/ready handshake on each
// side trades NIBBLES cycles of latency for a single small adder.

module four_bit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;      // already inverted for subtract
  logic [3:0]         nib_a;
  logic [3:0]         nib_b;
  logic [3:0]         nib_s;
  logic               nib_cout;
  logic               last;

  // The subtract flag is folded into b_q and the initial carry at accept
  // time, so no separate operation register is needed afterwards.

  assign last = (idx == IDX_W'(NIBBLES - 1));

  four_bit_cla u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Select the current nibble of both captured operands
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IDX_W'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, nibble-serial accumulation and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IDX_W'(k)) sum[4*k +: 4] <= nib_s;
          end
          carry <= nib_cout;
          if (last) begin
            cout     <= nib_cout;
            // Carry into the MSB xor carry out of the MSB
            overflow <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3] ^ nib_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=16): reset, a table of
// directed vectors, hand-written backpressure / back-to-back / mid-run reset
// sequences, and random operations against an arithmetic reference model.

module tb_cla_nibble_sequencer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: unsigned modular result, carry/no-borrow, signed range test
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int          sa;
    int          sb;
    int          r;
    logic [15:0] s;
    logic        c;
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      s = ma - mb;
      c = (ma >= mb);
      r = sa - sb;
    end else begin
      s = ma + mb + 16'(mcin);
      c = (int'(ma) + int'(mb) + int'(mcin)) > 65535;
      r = sa + sb + int'(mcin);
    end
    return {c, (r > 32767) || (r < -32768), s};
  endfunction

  // Wait for in_ready, issue one operation, wait for the result, then complete
  // the output handshake. Inputs are scrambled after the accept edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                        input logic tsub, output logic [15:0] rs, output logic rc,
                        output logic ro, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rs = sum; rc = cout; ro = overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  vec_t        vecs[8];
  logic [15:0] rs;
  logic        rc;
  logic        ro;
  int          lat;
  logic [17:0] exp;
  logic [15:0] hold_sum;
  logic        hold_cout;
  logic        hold_ovf;
  time         t0;
  time         t1;
  logic        found;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, rs, rc, ro, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_overflow", i), 32'(ro), 32'(vecs[i].exp_ovf));
    end

    // Backpressure with requests pulsed during RUN and DONE
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0000; b = 16'h0000; sub = 1'b1; cin = 1'b1;   // ignored request
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_sum", 32'(sum), 32'h8000);
    check("bp_cout", 32'(cout), 32'd0);
    check("bp_overflow", 32'(overflow), 32'd1);
    hold_sum = sum; hold_cout = cout; hold_ovf = overflow;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_sum", 32'(sum), 32'(hold_sum));
      check("bp_hold_flags", {30'd0, cout, overflow}, {30'd0, hold_cout, hold_ovf});
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back with out_ready tied high: issue period must be 6 cycles
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        check("b2b_first_sum", 32'(sum), 32'h2346);
      end
    end
    check("b2b_result_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (in_ready) found = 1'b1;
      else @(negedge clk);
    end
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    t1 = $time;
    #1;
    in_valid = 1'b0;
    check("b2b_period", 32'((t1 - t0) / 10), 32'd6);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        check("b2b_second_sum", 32'(sum), 32'h0003);
      end
    end
    check("b2b_second_seen", 32'(found), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset two cycles into RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'h0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check("midrst_no_out_valid", 32'(found), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("midrst_next_sum", 32'(rs), 32'h0100);
    check("midrst_next_latency", 32'(lat), 32'd4);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rcin;
      logic        rsub;
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000 | ra;
      exp = model(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, rs, rc, ro, lat);
      check($sformatf("rand%0d_sum", i), 32'(rs), 32'(exp[15:0]));
      check($sformatf("rand%0d_cout", i), 32'(rc), 32'(exp[17]));
      check($sformatf("rand%0d_overflow", i), 32'(ro), 32'(exp[16]));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide adder/subtractor built around a single shared `four_bit_cla` instance. It accepts WIDTH-bit operands over a valid/ready handshake and feeds them through the 4-bit carry-lookahead adder one nibble per clock, least-significant first. A registered carry chains between nibbles. It sits between an operand source (register file / test harness) and a result consumer, trading latency for area in the ALU datapath.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 8; NIBBLES = WIDTH/4
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1 = compute a - b, 0 = a + b + cin
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  final carry out; for sub, 1 = no borrow
- overflow  output  1  two's-complement signed overflow

## Operation
- One `four_bit_cla` instance. Its inputs are nibble `idx` of the captured A, nibble `idx` of the captured B', and the carry register. No other adder in the block.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture A <= a and B' <= (sub ? ~b : b).
  - Set carry <= (sub ? 1 : cin), idx <= 0, and latch the sub flag.
  - Go to RUN.
- RUN:
  - Each cycle: sum[4*idx+3:4*idx] <= S, carry <= Cout, idx <= idx+1.
  - On the cycle idx == NIBBLES-1, the same updates apply and the FSM goes to DONE.
  - cout <= Cout of the last nibble.
  - overflow <= A[WIDTH-1] ^ B'[WIDTH-1] ^ S[3] ^ Cout, using the top-nibble values. This equals carry-into-MSB xor carry-out.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On out_ready, go to IDLE. Outputs keep their values until the next operation overwrites them nibble by nibble.
- in_valid is ignored outside IDLE. a, b, cin and sub are sampled only on the accept edge and may change freely afterwards.
- idx width is clog2(NIBBLES), minimum 1 bit. idx never wraps past NIBBLES-1.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation is reported only through overflow.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - state=IDLE, idx=0, carry=0, A=B'=0.
  - sum=0, cout=0, overflow=0, out_valid=0, in_ready=1.
- Reset during RUN or DONE aborts the operation. No out_valid is produced for it, and partial sum bits are cleared.
- Accept edge T0 (in_valid & in_ready): the FSM is in RUN from T0+1.
- Nibble k is written at edge T0+1+k. DONE is entered at edge T0+NIBBLES, so out_valid is high starting in cycle T0+NIBBLES.
- Latency is NIBBLES cycles from accept to out_valid (4 for WIDTH=16).
- Handshake completes on the edge where out_valid & out_ready. in_ready rises the following cycle.
- Minimum issue interval is NIBBLES+2 cycles: IDLE accept, NIBBLES RUN cycles, one DONE cycle with out_ready=1.
- in_ready and out_valid are pure decodes of the state register. There is no combinational path from in_valid or out_ready to any output.
- out_ready held low keeps the FSM in DONE indefinitely with all outputs constant.

## Test plan
All scenarios use WIDTH=16.
- Reset: hold rst_n=0 -> in_ready=1, out_valid=0, sum=0x0000, cout=0, overflow=0; deassert and confirm idle.
- Add, carry ripple through all nibbles: a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, overflow=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 10 cycles after out_valid -> sum, cout and overflow do not change; in_ready stays 0.
  - Pulse in_valid with new operands during RUN and DONE -> request ignored and result unaffected.
  - Raise out_ready -> in_ready=1 on the next cycle.
- Back-to-back: issue 0x1234+0x1111 (cin=1) with out_ready tied high, then issue the next operation as soon as in_ready rises -> first result is sum=0x2346; issue period is exactly 6 cycles.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> immediately IDLE, sum=0x0000, out_valid never asserted. The next operation 0x00FF+0x0001 -> sum=0x0100.
